// File: rtl/ddr_global_pkg.sv
`default_nettype none
// ============================================================================
// ddr_global_pkg : shared types and constants for the ddr_fifo read-drain path
// Revision: 1.0
// ============================================================================
package ddr_global_pkg;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_STREAM = 2'd1,
    RD_PLAY   = 2'd2,
    RD_FLUSH  = 2'd3
  } ddr_rdrain_state_t;

  localparam logic [1:0] SKID_FULL = 2'd2;

endpackage
`default_nettype wire

// File: rtl/ddr_skid_buf_2.sv
`default_nettype none
// ============================================================================
// ddr_skid_buf_2 : two-entry registered skid buffer with valid/ready output
// Revision: 1.0
// ============================================================================
module ddr_skid_buf_2
  import ddr_global_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [DWIDTH-1:0] i_data,
  output logic              o_full,
  output logic              o_valid,
  output logic [DWIDTH-1:0] o_data,
  input  logic              i_ready
);

  logic [DWIDTH-1:0] mem_q [2];
  logic              rd_ptr_q;
  logic              wr_ptr_q;
  logic [1:0]        occ_q;
  logic [1:0]        occ_d;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (occ_q == SKID_FULL);
  assign o_valid = (occ_q != 2'd0);
  assign o_data  = mem_q[rd_ptr_q];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = o_valid & i_ready;

  always_comb begin
    occ_d = occ_q;
    case ({w_push, w_pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q] <= i_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (w_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ddr_fifo_rdrain.sv
`default_nettype none
// ============================================================================
// ddr_fifo_rdrain : FIFO read-side drain engine (stream / bounded playback)
// Optional stall counter: define DDR_FIFO_RDRAIN_STALL_CNT_EN
// Revision: 1.0
// ============================================================================
module ddr_fifo_rdrain
  import ddr_global_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int CWIDTH = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_stream_en,
  input  logic              i_play_start,
  input  logic [CWIDTH-1:0] i_play_cnt,
  input  logic              i_fifo_empty_n,
  input  logic [DWIDTH-1:0] i_fifo_rdata,
  output logic              o_fifo_read,
  output logic              o_valid,
  output logic [DWIDTH-1:0] o_data,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic [15:0]       o_stall_cnt
);

  ddr_rdrain_state_t state_q, state_d;
  logic [CWIDTH-1:0] rem_q, rem_d;
  logic              play_q, play_d;
  logic              done_q, done_d;
  logic              w_pop_en;
  logic              w_skid_full;

  // Stream pops stop in the very cycle i_stream_en drops, not one cycle later.
  assign w_pop_en = ((state_q == RD_STREAM) & i_stream_en) |
                    ((state_q == RD_PLAY) & (rem_q != '0));
  assign o_fifo_read = w_pop_en & i_fifo_empty_n & ~w_skid_full;
  assign o_busy      = (state_q != RD_IDLE);
  assign o_done      = done_q;

  ddr_skid_buf_2 #(
    .DWIDTH (DWIDTH)
  ) u_skid (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (o_fifo_read),
    .i_data  (i_fifo_rdata),
    .o_full  (w_skid_full),
    .o_valid (o_valid),
    .o_data  (o_data),
    .i_ready (i_ready)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    play_d  = play_q;
    done_d  = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (i_play_start) begin
          play_d  = 1'b1;
          rem_d   = i_play_cnt;
          state_d = (i_play_cnt == '0) ? RD_FLUSH : RD_PLAY;
        end else if (i_stream_en) begin
          play_d  = 1'b0;
          state_d = RD_STREAM;
        end
      end
      RD_STREAM: begin
        if (!i_stream_en) state_d = RD_FLUSH;
      end
      RD_PLAY: begin
        if (rem_q == '0) begin
          state_d = RD_FLUSH;
        end else if (o_fifo_read) begin
          rem_d = rem_q - CWIDTH'(1);
          if (rem_q == CWIDTH'(1)) state_d = RD_FLUSH;
        end
      end
      RD_FLUSH: begin
        if (!o_valid) begin
          state_d = RD_IDLE;
          done_d  = play_q;
          play_d  = 1'b0;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= RD_IDLE;
      rem_q   <= '0;
      play_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      play_q  <= play_d;
      done_q  <= done_d;
    end
  end

`ifdef DDR_FIFO_RDRAIN_STALL_CNT_EN
  logic [15:0] stall_q;
  logic        se_q;
  logic        w_stall_clr;

  // A new session from IDLE restarts the stall measurement.
  assign w_stall_clr = (state_q == RD_IDLE) & (i_play_start | (i_stream_en & ~se_q));
  assign o_stall_cnt = stall_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_q <= 16'h0000;
      se_q    <= 1'b0;
    end else begin
      se_q <= i_stream_en;
      if (w_stall_clr) begin
        stall_q <= 16'h0000;
      end else if (o_valid & ~i_ready & (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
    end
  end
`else
  assign o_stall_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ddr_fifo_rdrain.sv
`default_nettype none
// ============================================================================
// tb_ddr_fifo_rdrain : randomized self-checking bench with a queue-based model
// Revision: 1.0
// ============================================================================
module tb_ddr_fifo_rdrain;

  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          stream_en = 1'b0;
  logic          play_start = 1'b0;
  logic [CW-1:0] play_cnt = '0;
  logic          fifo_empty_n = 1'b0;
  logic [DW-1:0] fifo_rdata = '0;
  logic          ready = 1'b0;
  logic          fifo_read, valid, busy, done;
  logic [DW-1:0] data;
  logic [15:0]   stall_cnt;

  always #5 clk = ~clk;

  ddr_fifo_rdrain #(.DWIDTH(DW), .CWIDTH(CW)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_stream_en    (stream_en),
    .i_play_start   (play_start),
    .i_play_cnt     (play_cnt),
    .i_fifo_empty_n (fifo_empty_n),
    .i_fifo_rdata   (fifo_rdata),
    .o_fifo_read    (fifo_read),
    .o_valid        (valid),
    .o_data         (data),
    .i_ready        (ready),
    .o_busy         (busy),
    .o_done         (done),
    .o_stall_cnt    (stall_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model: FIFO contents, words in flight to downstream, session bookkeeping
  logic [31:0] fq[$];
  logic [31:0] exp_q[$];
  logic [31:0] acc_log[$];
  int          acc_cyc_log[$];
  bit          rd_log[$];
  bit          loop_mode = 0;
  bit          feed_rand = 0;
  bit          play_sess = 0;
  int          pops_left = 0;
  int          pops = 0, accepts = 0, dones = 0, cyc = 0;
  int          last_acc_cyc = 0, done_cyc = -1;
  bit          busy_at_done = 0;
  bit          prev_se = 0;
  int          stall_m = 0;

  task automatic step();
    logic [31:0] w;
    int occ;
    fifo_empty_n = (fq.size() != 0);
    fifo_rdata   = (fq.size() != 0) ? fq[0] : $urandom;
    #1;
`ifdef DDR_FIFO_RDRAIN_STALL_CNT_EN
    chk("stall_cnt", {16'h0, stall_cnt}, stall_m);
`else
    chk("stall_cnt", {16'h0, stall_cnt}, 32'h0);
`endif
    occ = exp_q.size();
    chk("valid", {31'h0, valid}, {31'h0, occ != 0});
    if (valid && occ != 0) chk("data", data, exp_q[0]);
    if (done) begin
      dones++;
      done_cyc     = cyc;
      busy_at_done = busy;
    end
    rd_log.push_back(fifo_read);
    if (fifo_read) begin
      chk("pop_nonempty", {31'h0, fq.size() != 0}, 32'h1);
      chk("pop_room", {31'h0, occ < 2}, 32'h1);
      chk("pop_allowed", {31'h0, play_sess ? (pops_left > 0) : stream_en}, 32'h1);
    end
    if (valid && ready && occ != 0) begin
      acc_log.push_back(exp_q.pop_front());
      acc_cyc_log.push_back(cyc);
      accepts++;
      last_acc_cyc = cyc;
    end
    if (fifo_read) begin
      if (fq.size() != 0) begin
        w = fq.pop_front();
        if (loop_mode) fq.push_back(w);
        exp_q.push_back(w);
      end
      pops++;
      if (pops_left > 0) pops_left--;
    end
    if (valid && !ready && stall_m != 32'hFFFF) stall_m++;
    if (!busy && (play_start || (stream_en && !prev_se))) stall_m = 0;
    prev_se = stream_en;
    if (feed_rand && $urandom_range(0, 2) != 0) fq.push_back($urandom);
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic drain(input string tag, input int pct, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      ready = ($urandom_range(0, 99) < pct);
      step();
      n++;
    end
    chk(tag, {31'h0, busy}, 32'h0);
  endtask

  task automatic clear_logs();
    pops = 0; accepts = 0; dones = 0; done_cyc = -1;
    acc_log.delete(); acc_cyc_log.delete(); rd_log.delete();
  endtask

  task automatic run_stream(input int on_cyc, input int pct);
    clear_logs();
    play_sess = 0;
    loop_mode = 0;
    stream_en = 1'b1;
    for (int i = 0; i < on_cyc; i++) begin
      ready = ($urandom_range(0, 99) < pct);
      step();
    end
    stream_en = 1'b0;
    drain("stream_timeout", pct, 300);
    step();
    chk("stream_no_done", dones, 0);
    chk("stream_lossless", accepts, pops);
    chk("stream_empty", exp_q.size(), 0);
  endtask

  task automatic run_play(input int cnt, input int pct);
    logic [31:0] snap[$];
    int st;
    snap = fq;
    loop_mode = 1;
    clear_logs();
    play_sess = 1;
    pops_left = cnt;
    play_cnt   = CW'(cnt);
    play_start = 1'b1;
    ready = ($urandom_range(0, 99) < pct);
    st = cyc;
    step();
    play_start = 1'b0;
    play_cnt   = CW'($urandom);
    drain("play_timeout", pct, 400);
    ready = ($urandom_range(0, 99) < pct);
    step();
    chk("play_pops", pops, cnt);
    chk("play_accepts", accepts, cnt);
    chk("play_done_count", dones, 1);
    chk("busy_at_done", {31'h0, busy_at_done}, 32'h0);
    if (cnt == 0) chk("zero_done_latency", {31'h0, (done_cyc > st) && (done_cyc - st <= 2)}, 32'h1);
    else          chk("done_latency", done_cyc, last_acc_cyc + 2);
    for (int i = 0; i < acc_log.size(); i++) chk("play_order", acc_log[i], snap[i % snap.size()]);
    play_sess = 0;
    loop_mode = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: pop strobe must stay low even with data and stream enable present
    stream_en    = 1'b1;
    fifo_empty_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_fifo_read", {31'h0, fifo_read}, 32'h0);
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", {31'h0, valid}, 32'h0);
    chk("rst_data", data, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_stall", {16'h0, stall_cnt}, 32'h0);
    stream_en = 1'b0;
    rst_n     = 1'b1;
    step();

    // Stream basic
    fq = '{32'h11, 32'h22, 32'h33};
    clear_logs();
    ready = 1'b1;
    stream_en = 1'b1;
    repeat (6) step();
    chk("sb_rd0", {31'h0, rd_log[0]}, 32'h0);
    for (int i = 1; i <= 3; i++) chk("sb_rd", {31'h0, rd_log[i]}, 32'h1);
    chk("sb_rd4", {31'h0, rd_log[4]}, 32'h0);
    chk("sb_n", acc_log.size(), 3);
    if (acc_log.size() == 3) begin
      chk("sb_w0", acc_log[0], 32'h11);
      chk("sb_w1", acc_log[1], 32'h22);
      chk("sb_w2", acc_log[2], 32'h33);
      chk("sb_consec1", acc_cyc_log[1], acc_cyc_log[0] + 1);
      chk("sb_consec2", acc_cyc_log[2], acc_cyc_log[0] + 2);
    end
    stream_en = 1'b0;
    drain("sb_idle", 100, 20);

    // Backpressure: two pops then hold word 0
    fq = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4};
    clear_logs();
    ready = 1'b0;
    stream_en = 1'b1;
    repeat (7) step();
    chk("bp_pops", pops, 2);
    chk("bp_hold", data, 32'hA0);
    ready = 1'b1;
    repeat (8) step();
    chk("bp_accepts", accepts, 5);
    for (int i = 0; i < acc_log.size(); i++) chk("bp_order", acc_log[i], 32'hA0 + i);
    stream_en = 1'b0;
    drain("bp_idle", 100, 20);

    // Seven stall cycles after a fresh stream start
    fq = '{32'h1, 32'h2, 32'h3};
    ready = 1'b0;
    stream_en = 1'b1;
    repeat (9) step();
`ifdef DDR_FIFO_RDRAIN_STALL_CNT_EN
    chk("stall_seven", {16'h0, stall_cnt}, 32'd7);
`else
    chk("stall_off", {16'h0, stall_cnt}, 32'd0);
`endif
    ready = 1'b1;
    stream_en = 1'b0;
    drain("stall_idle", 100, 20);
    fq.delete();

    // Playback of 10 from a 4-word loop FIFO, then zero count
    fq = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
    run_play(10, 100);
    run_play(0, 100);

    // Stream disable with two words buffered
    fq = '{32'hD0, 32'hD1, 32'hD2, 32'hD3, 32'hD4, 32'hD5};
    clear_logs();
    ready = 1'b0;
    stream_en = 1'b1;
    repeat (4) step();
    stream_en = 1'b0;
    repeat (2) step();
    chk("dis_pops", pops, 2);
    ready = 1'b1;
    drain("dis_idle", 100, 20);
    step();
    chk("dis_accepts", accepts, 2);
    chk("dis_no_done", dones, 0);
    fq.delete();

    // Asynchronous reset mid-stream
    fq = '{32'hE0, 32'hE1, 32'hE2, 32'hE3, 32'hE4, 32'hE5};
    ready = 1'b0;
    stream_en = 1'b1;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'h0, valid}, 32'h0);
    chk("arst_busy", {31'h0, busy}, 32'h0);
    chk("arst_read", {31'h0, fifo_read}, 32'h0);
    exp_q.delete();
    fq.delete();
    stall_m   = 0;
    prev_se   = 0;
    stream_en = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step();

    // Randomized sessions
    for (int s = 0; s < 16; s++) begin
      fq.delete();
      if ($urandom_range(0, 1) != 0) begin
        feed_rand = 1;
        run_stream($urandom_range(3, 25), $urandom_range(30, 100));
        feed_rand = 0;
      end else begin
        repeat ($urandom_range(1, 5)) fq.push_back($urandom);
        run_play($urandom_range(0, 12), $urandom_range(30, 100));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ddr_fifo_rdrain.md
# ddr_fifo_rdrain

Single-clock read-side drain engine for a `ddr_fifo` read port. It pops words from the FIFO and presents them downstream on a registered valid/ready interface through a 2-entry skid buffer, sustaining one word per cycle. It supports continuous streaming, and bounded playback of N pops for FIFOs running in loop mode.

## Interface
Parameters:
- `DWIDTH`, 32, FIFO read data width and downstream data width.
- `CWIDTH`, 16, width of the playback count.

Ports:
- `i_clk`  in  1  read clock; the same clock as the FIFO `i_rclk`.
- `i_rst_n`  in  1  reset, asynchronous assert, active-low.
- `i_stream_en`  in  1  level; enables continuous drain whenever the engine is idle.
- `i_play_start`  in  1  pulse; starts a bounded playback of `i_play_cnt` pops.
- `i_play_cnt`  in  CWIDTH  playback pop count, sampled on `i_play_start`.
- `i_fifo_empty_n`  in  1  FIFO not-empty flag.
- `i_fifo_rdata`  in  DWIDTH  FIFO head data, valid combinationally while `i_fifo_empty_n` is high.
- `o_fifo_read`  out  1  FIFO pop strobe, combinational.
- `o_valid`  out  1  downstream valid.
- `o_data`  out  DWIDTH  downstream data.
- `i_ready`  in  1  downstream ready.
- `o_busy`  out  1  high when not in IDLE.
- `o_done`  out  1  one-cycle pulse when a playback completes.
- `o_stall_cnt`  out  16  stall counter; present only with the configuration macro.

## Operation
**States:** IDLE, STREAM, PLAY, FLUSH.
- IDLE → PLAY on `i_play_start`. Playback has priority if `i_stream_en` is also high.
- IDLE → STREAM on `i_stream_en`.
- STREAM → FLUSH when `i_stream_en` falls.
- PLAY → FLUSH when the remaining count reaches 0 after a pop.
- FLUSH → IDLE when the skid buffer is empty.
- `i_play_start` is ignored outside IDLE.
- `i_play_cnt` = 0: go IDLE → FLUSH, with no pops; `o_done` pulses on the FLUSH → IDLE transition.

**Pop rule:**
- `o_fifo_read` = (state is STREAM, or PLAY with remaining > 0) & `i_fifo_empty_n` & (skid occupancy < 2).
- The popped word is written into the skid buffer on the same edge.

**Skid buffer:**
- 2-entry FIFO with 2-bit occupancy, range 0..2.
- `o_valid` = occupancy ≠ 0. `o_data` is the head entry.
- A transfer occurs when `o_valid & i_ready`.
- A simultaneous push and pop leaves occupancy unchanged.
- Data must not change while `o_valid & !i_ready`.

**Playback counter:**
- Loaded from `i_play_cnt` on start.
- Decrements on each pop; never underflows.
- `o_done` fires on the FLUSH → IDLE transition that ends a playback, i.e. after the last word is accepted downstream.
- `o_done` never fires for stream sessions.

**Dropping `i_stream_en`:** pops stop on the same cycle. Buffered words are still delivered.

## Timing
- **Reset values:** `o_valid`=0, `o_data`=0, `o_done`=0, `o_busy`=0, `o_stall_cnt`=0, state IDLE, occupancy 0. `o_fifo_read`=0 during reset.
- **Latency:**
  - FIFO word popped at edge k appears on `o_valid`/`o_data` after edge k.
  - `i_stream_en` or `i_play_start` sampled at edge k: first pop is possible in cycle k+1.
- **Throughput:** one word per cycle while `i_ready` is held high and the FIFO is non-empty. Occupancy then stays at 1.
- **Backpressure:** with `i_ready` low, at most 2 pops occur, then `o_fifo_read` stays low.
- **Reset mid-operation:** reset clears all state immediately, and buffered words are discarded. The FIFO pointers are the FIFO's responsibility.

## Configuration
Macro: `DDR_FIFO_RDRAIN_STALL_CNT_EN`.
- **Defined:** `o_stall_cnt` increments on every cycle with `o_valid & !i_ready`. It saturates at 16'hFFFF and clears on `i_play_start` or a rising edge of `i_stream_en` taken from IDLE.
- **Undefined:** the counter logic is not built and `o_stall_cnt` is tied to 0.

## Structure
- A typedef enum for the state encoding (IDLE=0, STREAM=1, PLAY=2, FLUSH=3) goes in `ddr_global_pkg`, as `ddr_rdrain_state_t`.
- The skid buffer is one sub-module, `ddr_skid_buf_2`, parameterized by `DWIDTH`.
- The FSM, playback counter and stall counter stay in the top module.

## Test plan
- **Stream basic:** FIFO holds 0x11, 0x22, 0x33; `i_stream_en`=1; `i_ready`=1 → 3 consecutive `o_fifo_read` cycles, and the outputs are 0x11, 0x22, 0x33 on 3 consecutive cycles.
- **Backpressure:** 5 words queued, `i_ready`=0 for 6 cycles → exactly 2 pops, `o_data` held at word 0; on release, all 5 words are delivered in order with no loss.
- **Playback:** FIFO in loop mode holding 4 words, `i_play_cnt`=10 → exactly 10 pops (words 0..3 repeating); `o_done` pulses once, one cycle after the 10th word is accepted; `o_busy` then falls.
- **Zero count:** `i_play_cnt`=0 → no pops; `o_done` pulses within 2 cycles.
- **Stream disable and reset:**
  - Drop `i_stream_en` with 2 words buffered → no further pops, both words delivered, state returns to IDLE, no `o_done`.
  - Assert `i_rst_n`=0 mid-stream → `o_valid` goes low asynchronously.
- **Stall counter (macro defined):** 7 stall cycles → `o_stall_cnt`=7. With the macro undefined, the count stays 0.
